// File: rtl/music_player_if.sv
// Game-side control and buzzer outputs of the music player, bundled for port hookup.
// master = game FSM / bench side, slave = music_player.
interface music_player_if;
  logic       i_play;
  logic [1:0] i_music_ind;
  logic       o_tone;
  logic       o_busy;
  logic       o_music_stop;
  logic [3:0] o_note_idx;

  modport master (
    output i_play, i_music_ind,
    input  o_tone, o_busy, o_music_stop, o_note_idx
  );

  modport slave (
    input  i_play, i_music_ind,
    output o_tone, o_busy, o_music_stop, o_note_idx
  );
endinterface

// File: rtl/music_player.sv
// Square-wave note sequencer: a rising edge of i_play loads a 16-entry track and plays it.
// Starts one cycle after the edge; no backpressure, a new edge always restarts playback.
module music_player #(
  parameter string          FILE      = "music.mem",
  parameter int             TICK_DIV  = 250000,
  parameter int             HP_UNIT   = 500,
  parameter logic [1023:0]  ROM_IMAGE = '0
) (
  input  logic           i_clk_25,
  input  logic           i_rst,
  music_player_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t      state_q, state_d;
  logic        play_q;
  logic [5:0]  addr_q, addr_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  dur_q, dur_d;
  logic [31:0] hp_q, hp_d;
  logic        tone_q, tone_d;
  logic [15:0] rom_q;
  logic [15:0] rom [64];

  for (genvar a = 0; a < 64; a++) begin : g_ent
    assign rom[a] = ROM_IMAGE[a*16 +: 16];
  end

  always_ff @(posedge i_clk_25) begin
    rom_q <= rom[addr_q];
  end

  logic        start;
  logic [6:0]  hp;
  logic [7:0]  dur_last;
  logic [31:0] hp_lim;
  logic        tick_end, note_end, last;

  assign start    = bus.i_play & ~play_q;
  assign hp       = rom_q[14:8];
  assign dur_last = (rom_q[7:0] == 8'd0) ? 8'd0 : rom_q[7:0] - 8'd1;
  assign hp_lim   = 32'(hp) * 32'(HP_UNIT);
  assign tick_end = (tick_q == 32'(TICK_DIV - 1));
  assign note_end = tick_end && (dur_q == dur_last);
  assign last     = rom_q[15] || (idx_q == 4'd15);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    tone_d  = tone_q;
    case (state_q)
      IDLE: tone_d = 1'b0;
      LOAD: begin
        state_d = PLAY;
        tick_d  = '0;
        dur_d   = '0;
        hp_d    = '0;
        tone_d  = 1'b0;
      end
      PLAY: begin
        tick_d = tick_end ? '0 : tick_q + 32'd1;
        if (tick_end) dur_d = dur_q + 8'd1;
        if (hp != 7'd0) begin
          if (hp_q == hp_lim - 32'd1) begin
            hp_d   = '0;
            tone_d = ~tone_q;
          end else begin
            hp_d = hp_q + 32'd1;
          end
        end
        if (note_end) begin
          tone_d = 1'b0;
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            addr_d  = addr_q + 6'd1;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        tone_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge overrides whatever the track was doing, including DONE.
    if (start) begin
      state_d = LOAD;
      addr_d  = {bus.i_music_ind, 4'd0};
      idx_d   = '0;
      tick_d  = '0;
      dur_d   = '0;
      hp_d    = '0;
      tone_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      state_q <= IDLE;
      play_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      play_q  <= bus.i_play;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
    end
  end

  assign bus.o_tone       = tone_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_music_stop = (state_q == DONE);
  assign bus.o_note_idx   = idx_q;

endmodule
